eth_tx_sched: RTL and testbench

- Packet-level scheduler/arbiter in front of the Ethernet TX encapsulator.
- Shares one TX path between NUM_SRC RTP packet sources: source 0 = ST2110-20 video; sources 1..NUM_SRC-1 = ST2110-30 audio / -40 ancillary.
- Grants one whole packet at a time (valid/ready/last handshake) and enforces a minimum inter-packet gap.
- Bounds video bursts so audio/ANC packets are never starved.

---
 rtl/eth_tx_sched.sv | 150 +++++++++++++++
 tb/tb_eth_tx_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched.sv
// Packet-level TX arbiter: shares one encapsulator path between a video source (0)
// and NUM_SRC-1 audio/ANC sources, granting whole packets and enforcing an inter-packet gap.
module eth_tx_sched #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_SRC         = 3,
    parameter int IPG_CYCLES      = 3,
    parameter int MAX_VIDEO_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    output logic                          tx_last,
    input  logic                          tx_ready,
    output logic [2:0]                    grant_id,
    output logic                          busy,
    output logic [31:0]                   pkt_cnt
);

    typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} state_t;

    state_t     state;
    logic [3:0] burst_cnt;
    logic [3:0] gap_cnt;
    logic [2:0] rr_ptr;

    // Sources padded out to 8 entries so the 3-bit grant index always selects in range.
    logic [DATA_WIDTH-1:0] beat [8];
    logic [7:0]            valid8;
    logic [7:0]            last8;

    logic       others_req;
    logic       video_win;
    logic       rr_found;
    logic [2:0] rr_pick;
    logic [2:0] rr_next;
    logic [3:0] cand;
    logic       pkt_done;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        valid8 = '0;
        last8  = '0;
        for (int i = 0; i < 8; i++) begin
            beat[i] = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            beat[i]   = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            valid8[i] = src_valid[i];
            last8[i]  = src_last[i];
        end
    end

    // Video wins unless it has used up its burst while someone else is waiting;
    // otherwise round-robin over sources 1..NUM_SRC-1 starting at rr_ptr.
    always_comb begin
        others_req = |src_valid[NUM_SRC-1:1];
        video_win  = src_valid[0] && ((burst_cnt < 4'(MAX_VIDEO_BURST)) || !others_req);
        rr_found   = 1'b0;
        rr_pick    = 3'd1;
        cand       = '0;
        for (int k = 0; k < NUM_SRC - 1; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NUM_SRC)) begin
                cand = cand - 4'(NUM_SRC - 1);
            end
            if (!rr_found && valid8[cand[2:0]]) begin
                rr_found = 1'b1;
                rr_pick  = cand[2:0];
            end
        end
        rr_next = (rr_pick == 3'(NUM_SRC - 1)) ? 3'd1 : rr_pick + 3'd1;
    end

    always_comb begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        src_ready = '0;
        if (state == XFER) begin
            tx_data  = beat[grant_id];
            tx_valid = valid8[grant_id];
            tx_last  = last8[grant_id] & valid8[grant_id];
            for (int i = 0; i < NUM_SRC; i++) begin
                src_ready[i] = tx_ready && (grant_id == 3'(i));
            end
        end
        busy     = (state != IDLE);
        pkt_done = tx_valid && tx_ready && tx_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= '0;
            pkt_cnt   <= '0;
            burst_cnt <= '0;
            rr_ptr    <= 3'd1;
            gap_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|src_valid) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (video_win) begin
                        grant_id  <= '0;
                        burst_cnt <= sat_inc(burst_cnt);
                        state     <= XFER;
                    end else if (rr_found) begin
                        grant_id  <= rr_pick;
                        burst_cnt <= '0;
                        rr_ptr    <= rr_next;
                        state     <= XFER;
                    end else begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    if (pkt_done) begin
                        pkt_cnt <= pkt_cnt + 32'd1;
                        if (IPG_CYCLES > 0) begin
                            gap_cnt <= 4'(IPG_CYCLES);
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt <= 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: randomized packet sources checked against a
// transaction/timeline reference model, plus directed grant-order, reset and zero-gap cases.
module tb_eth_tx_sched;

    localparam int NS  = 3;
    localparam int DW  = 32;
    localparam int IPG = 3;
    localparam int MVB = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_valid, src_last, src_ready;
    logic [DW-1:0]    tx_data;
    logic             tx_valid, tx_last, tx_ready;
    logic [2:0]       grant_id;
    logic             busy;
    logic [31:0]      pkt_cnt;

    logic [NS*DW-1:0] b_src_data;
    logic [NS-1:0]    b_src_valid, b_src_last, b_src_ready;
    logic [DW-1:0]    b_tx_data;
    logic             b_tx_valid, b_tx_last, b_tx_ready;
    logic [2:0]       b_grant_id;
    logic             b_busy;
    logic [31:0]      b_pkt_cnt;

    eth_tx_sched #(.DATA_WIDTH(DW), .NUM_SRC(NS), .IPG_CYCLES(IPG), .MAX_VIDEO_BURST(MVB)) u_dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
        .src_last(src_last), .src_ready(src_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy),
        .pkt_cnt(pkt_cnt)
    );

    eth_tx_sched #(.DATA_WIDTH(DW), .NUM_SRC(NS), .IPG_CYCLES(0), .MAX_VIDEO_BURST(MVB)) u_dut_nogap (
        .clk(clk), .rst_n(rst_n), .src_data(b_src_data), .src_valid(b_src_valid),
        .src_last(b_src_last), .src_ready(b_src_ready), .tx_data(b_tx_data),
        .tx_valid(b_tx_valid), .tx_last(b_tx_last), .tx_ready(b_tx_ready),
        .grant_id(b_grant_id), .busy(b_busy), .pkt_cnt(b_pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source side: each source owns a queue depth, current packet length and beat index.
    int pend [NS];
    int plen [NS];
    int bidx [NS];
    int seq  [NS];
    int len_min = 1, len_max = 4, bubble_pct = 0, rdy_pct = 100, arr_pct = 0;
    logic [NS-1:0] arr_mask = '0;
    logic [NS-1:0] hs = '0;

    // Reference timeline: when the scheduler is free again, when it arbitrates, who owns the path.
    int n = 0;
    int next_free, arb_cyc, g_m, burst_m, ptr_m, grant_m, pkts_m, first_tx;
    bit in_pkt, new_pkt;
    int grant_log [$];
    logic [DW-1:0] tx_log [$];

    task automatic model_reset();
        in_pkt    = 0;
        new_pkt   = 0;
        arb_cyc   = -1;
        next_free = n;
        burst_m   = 0;
        ptr_m     = 1;
        grant_m   = 0;
        pkts_m    = 0;
        first_tx  = -1;
        grant_log.delete();
        tx_log.delete();
    endtask

    task automatic arbitrate(input logic [NS-1:0] req, output int win);
        bit others;
        int c;
        others = 0;
        win    = -1;
        for (int i = 1; i < NS; i++) if (req[i]) others = 1;
        if (req[0] && (burst_m < MVB || !others)) begin
            win = 0;
            if (burst_m < 15) burst_m++;
        end else begin
            for (int k = 0; k < NS - 1; k++) begin
                c = 1 + ((ptr_m - 1 + k) % (NS - 1));
                if (win < 0 && req[c]) begin
                    win     = c;
                    burst_m = 0;
                    ptr_m   = 1 + (c % (NS - 1));
                end
            end
        end
    endtask

    task automatic model_step();
        logic [NS-1:0] exp_rdy;
        int win;
        bit exp_last;
        hs = src_valid & src_ready;
        chk("pkt_cnt", pkt_cnt, pkts_m);
        chk("grant_id", grant_id, grant_m);
        if (tx_valid && first_tx < 0) first_tx = n;
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (in_pkt) begin
            if (new_pkt) begin
                grant_log.push_back(int'(grant_id));
                new_pkt = 0;
            end
            exp_rdy        = '0;
            exp_rdy[g_m]   = tx_ready;
            exp_last       = src_valid[g_m] && (bidx[g_m] == plen[g_m] - 1);
            chk("busy_xfer", busy, 1);
            chk("src_ready", src_ready, exp_rdy);
            chk("tx_valid", tx_valid, src_valid[g_m]);
            chk("tx_last", tx_last, exp_last);
            if (src_valid[g_m]) chk("tx_data", tx_data, {8'(g_m), 8'(seq[g_m]), 16'(bidx[g_m])});
            if (exp_last && tx_ready) begin
                in_pkt    = 0;
                pkts_m++;
                next_free = n + IPG + 1;
            end
        end else begin
            chk("src_ready_off", src_ready, 0);
            chk("tx_valid_off", tx_valid, 0);
            chk("tx_last_off", tx_last, 0);
            chk("tx_data_off", tx_data, 0);
            if (n == arb_cyc) begin
                chk("busy_arb", busy, 1);
                arbitrate(src_valid, win);
                arb_cyc = -1;
                if (win >= 0) begin
                    in_pkt  = 1;
                    new_pkt = 1;
                    g_m     = win;
                    grant_m = win;
                end else begin
                    next_free = n + 1;
                end
            end else begin
                chk("busy", busy, n < next_free);
                if (n >= next_free && src_valid != '0) arb_cyc = n + 1;
            end
        end
        n++;
    endtask

    task automatic drive_step();
        bit v;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                if (bidx[i] == plen[i] - 1) begin
                    bidx[i] = 0;
                    seq[i]++;
                    pend[i]--;
                    plen[i] = $urandom_range(len_max, len_min);
                end else begin
                    bidx[i]++;
                end
            end
            if (arr_mask[i] && $urandom_range(99, 0) < arr_pct) pend[i]++;
            v = (pend[i] > 0) && !($urandom_range(99, 0) < bubble_pct);
            src_valid[i]          = v;
            src_data[i*DW +: DW]  = {8'(i), 8'(seq[i]), 16'(bidx[i])};
            src_last[i]           = v ? (bidx[i] == plen[i] - 1) : 1'($urandom_range(1, 0));
        end
        tx_ready = $urandom_range(99, 0) < rdy_pct;
    endtask

    task automatic run_cycles(input int cyc);
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
            drive_step();
        end
    endtask

    task automatic clear_sources();
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        tx_ready  = 1'b0;
        hs        = '0;
        for (int i = 0; i < NS; i++) begin
            pend[i] = 0;
            bidx[i] = 0;
            seq[i]  = 0;
            plen[i] = $urandom_range(len_max, len_min);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_sources();
        @(posedge clk);
        #2;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int pat_v [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int pat_a [6]  = '{1, 2, 1, 2, 1, 2};
        int n0, total, bcnt, pk, idle_run;
        bit reached, after_last, b_hs;

        rst_n       = 1'b0;
        src_valid   = '0;
        src_last    = '0;
        src_data    = '0;
        tx_ready    = 1'b0;
        b_src_valid = '0;
        b_src_last  = '0;
        b_src_data  = '0;
        b_tx_ready  = 1'b1;

        // Single 4-beat video packet: latency, beat order, count, gap.
        len_min = 4; len_max = 4; bubble_pct = 0; rdy_pct = 100; arr_pct = 0; arr_mask = '0;
        apply_reset();
        pend[0] = 1;
        n0 = n;
        drive_step();
        run_cycles(15);
        chk("s1_latency", first_tx, n0 + 2);
        chk("s1_beats", tx_log.size(), 4);
        for (int b = 0; b < 4; b++)
            chk("s1_beat", (b < tx_log.size()) ? tx_log[b] : 32'hFFFF_FFFF, {16'd0, 16'(b)});
        chk("s1_pkt_cnt", pkt_cnt, 1);

        // Video and audio both saturated with 1-beat packets: bounded video burst.
        len_min = 1; len_max = 1;
        apply_reset();
        pend[0] = 1000;
        pend[1] = 1000;
        drive_step();
        run_cycles(70);
        for (int i = 0; i < 10; i++)
            chk("s2_grant", (i < grant_log.size()) ? grant_log[i] : -1, pat_v[i]);

        // Audio sources 1 and 2 saturated, video idle: round-robin wraps.
        apply_reset();
        pend[1] = 1000;
        pend[2] = 1000;
        drive_step();
        run_cycles(45);
        for (int i = 0; i < 6; i++)
            chk("s3_grant", (i < grant_log.size()) ? grant_log[i] : -1, pat_a[i]);

        // Random traffic with bubbles, backpressure and stray src_last.
        len_min = 1; len_max = 5; bubble_pct = 25; rdy_pct = 65; arr_pct = 4; arr_mask = '1;
        apply_reset();
        drive_step();
        run_cycles(3000);
        total = 0;
        for (int i = 0; i < NS; i++) total += seq[i];
        chk("s4_pkt_total", pkt_cnt, total);
        chk("s4_pkt_model", pkt_cnt, pkts_m);

        // Reset asserted during the second beat of a 5-beat packet.
        len_min = 5; len_max = 5; bubble_pct = 0; rdy_pct = 100; arr_pct = 0; arr_mask = '0;
        apply_reset();
        pend[0] = 1;
        drive_step();
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            run_cycles(1);
            if (bidx[0] == 1) reached = 1;
        end
        chk("s5_reached_beat2", reached, 1);
        #2;
        chk("s5_pre_tx_valid", tx_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("s5_tx_valid", tx_valid, 0);
        chk("s5_src_ready", src_ready, 0);
        chk("s5_busy", busy, 0);
        chk("s5_pkt_cnt", pkt_cnt, 0);
        chk("s5_grant_id", grant_id, 0);
        len_min = 2; len_max = 2;
        clear_sources();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        pend[1] = 1;
        drive_step();
        run_cycles(20);
        chk("s5_next_pkt_cnt", pkt_cnt, 1);
        chk("s5_next_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

        // Zero-gap instance: back-to-back 2-beat video packets.
        bcnt       = 0;
        pk         = 0;
        idle_run   = 0;
        after_last = 0;
        first_tx   = -1;
        @(posedge clk);
        #1;
        b_src_valid = 3'b001;
        b_src_data  = '0;
        b_src_last  = 3'b000;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("b_pkt_cnt", b_pkt_cnt, pk);
            chk("b_ready_others", b_src_ready[2:1], 0);
            b_hs = b_src_valid[0] & b_src_ready[0];
            if (b_tx_valid) begin
                if (first_tx < 0) begin
                    first_tx = c;
                    chk("b_latency", c, 2);
                end
                if (after_last) begin
                    chk("b_gap", idle_run, 2);
                    after_last = 0;
                end
                chk("b_tx_data", b_tx_data, bcnt);
                chk("b_tx_last", b_tx_last, bcnt % 2 == 1);
                if (b_tx_ready && (bcnt % 2 == 1)) begin
                    pk++;
                    after_last = 1;
                    idle_run   = 0;
                end
            end else if (after_last) begin
                idle_run++;
            end
            @(posedge clk);
            #1;
            if (b_hs) bcnt++;
            b_src_data[DW-1:0] = 32'(bcnt);
            b_src_last         = {2'b00, 1'(bcnt % 2 == 1)};
        end
        chk("b_total", b_pkt_cnt, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
